// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_pkg;

    // Execute-stage operand source select
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // Data-memory wait tracking
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    localparam int PERF_W = 16;

endpackage

// File: rtl/forward_unit.sv
// Forwarding select for one execute-stage operand; memory-stage result beats writeback.
// Latency: purely combinational, same cycle.
// Backpressure: none; the select simply follows its inputs.
module forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_BITS = 4
) (
    input  logic [REG_BITS-1:0] ra_e,
    input  logic [REG_BITS-1:0] wa_m,
    input  logic [REG_BITS-1:0] wa_w,
    input  logic                reg_write_m,
    input  logic                reg_write_w,
    output fwd_sel_t            fwd_sel
);

    // Youngest producer wins; register 0 is an ordinary register here
    always_comb begin
        fwd_sel = FWD_REG;
        if (reg_write_m && (wa_m == ra_e)) begin
            fwd_sel = FWD_MEM;
        end else if (reg_write_w && (wa_w == ra_e)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller: forward selects, load-use stall, branch flush, memory-wait freeze with timeout.
// Latency: all outputs combinational from inputs and state; state/counter/mem_err update on clk.
// Backpressure: a pending data-memory access freezes F/D/E/M and bubbles W until ready or timeout.
// Optional HAZARD_PERF_EN adds saturating stall_cycles / flush_events counters.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_BITS    = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_BITS-1:0] ra1_d,
    input  logic [REG_BITS-1:0] ra2_d,
    input  logic [REG_BITS-1:0] ra1_e,
    input  logic [REG_BITS-1:0] ra2_e,
    input  logic [REG_BITS-1:0] wa_e,
    input  logic [REG_BITS-1:0] wa_m,
    input  logic [REG_BITS-1:0] wa_w,
    input  logic                reg_write_m,
    input  logic                reg_write_w,
    input  logic                mem_to_reg_e,
    input  logic                branch_taken_e,
    input  logic                mem_req_m,
    input  logic                mem_ready,
    output logic [1:0]          forwardAE,
    output logic [1:0]          forwardBE,
    output logic                stall_f,
    output logic                stall_d,
    output logic                stall_e,
    output logic                stall_m,
    output logic                flush_d,
    output logic                flush_e,
    output logic                flush_w,
    output logic                mem_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0]   stall_cycles,
    output logic [PERF_W-1:0]   flush_events
`endif
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_err_q, mem_err_d;
    fwd_sel_t         fwd_a, fwd_b;
    logic             mem_miss, timeout, freeze, load_use;

    forward_unit #(.REG_BITS(REG_BITS)) u_fwd_a (
        .ra_e        (ra1_e),
        .wa_m        (wa_m),
        .wa_w        (wa_w),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .fwd_sel     (fwd_a)
    );

    forward_unit #(.REG_BITS(REG_BITS)) u_fwd_b (
        .ra_e        (ra2_e),
        .wa_m        (wa_m),
        .wa_w        (wa_w),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .fwd_sel     (fwd_b)
    );

    assign mem_miss = mem_req_m && !mem_ready;
    assign timeout  = (state_q == MEM_WAIT) && !mem_ready && (cnt_q == CNT_W'(MEM_TIMEOUT));
    assign load_use = mem_to_reg_e && ((wa_e == ra1_d) || (wa_e == ra2_d));

    // Freeze on a fresh miss, and while waiting unless memory answers or the wait times out
    always_comb begin
        freeze = 1'b0;
        if (state_q == RUN) begin
            freeze = mem_miss;
        end else begin
            freeze = !mem_ready && !timeout;
        end
    end

    // Wait FSM next state; counter counts waited cycles and clears on every return to RUN
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_err_d = mem_err_q;
        case (state_q)
            RUN: begin
                if (mem_miss) begin
                    state_d = MEM_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (timeout) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    mem_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Wait state, counter and sticky error register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Stall/flush encoding, freeze > branch > load-use; everything held low during reset.
    // A branch held through a freeze flushes on the release cycle, when E finally advances.
    always_comb begin
        forwardAE = FWD_REG;
        forwardBE = FWD_REG;
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        stall_m   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        flush_w   = 1'b0;
        if (rst) begin
            forwardAE = fwd_a;
            forwardBE = fwd_b;
            if (freeze) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (branch_taken_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (load_use) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [PERF_W-1:0] flush_events_q, flush_events_d;

    // Saturating event counters; a branch flush is the only source of flush_d
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (stall_f && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + PERF_W'(1);
        end
        if (flush_d && (flush_events_q != '1)) begin
            flush_events_d = flush_events_q + PERF_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`endif

endmodule
